ps2_key_scroll: RTL



---
 rtl/ps2_key_scroll_pkg.sv | 46 ++++
 rtl/ps2_frame_rx.sv | 97 +++++++++
 rtl/ps2_key_scroll.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/ps2_key_scroll_pkg.sv
// Set-2 scancodes, decoder states and 7-segment glyphs shared by the PS/2 letter-scroll display.
// Constants and pure functions only: no latency, no backpressure.
package ps2_key_scroll_pkg;

  localparam logic [7:0] SC_BREAK = 8'hF0;
  localparam logic [7:0] SC_EXT   = 8'hE0;
  localparam logic [7:0] SC_BKSP  = 8'h66;
  localparam logic [7:0] SC_ENTER = 8'h5A;

  // Make codes for A..Z in alphabetical order; position + 1 is the letter index.
  localparam logic [7:0] SC_LETTERS [26] = '{
    8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43,
    8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D,
    8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A
  };

  // Active-low {dp,g,f,e,d,c,b,a}; dp bit held high so the point never lights.
  localparam logic [7:0] SEG_DIGITS [10] = '{
    8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8, 8'h80, 8'h90
  };
  localparam logic [7:0] SEG_BLANK = 8'hFF;

  typedef enum logic [1:0] {
    DEC_IDLE,
    DEC_BREAK,
    DEC_EXT,
    DEC_EXT_BREAK
  } dec_state_e;

  function automatic logic [4:0] letter_idx(input logic [7:0] code);
    logic [4:0] idx;
    idx = '0;
    for (int i = 0; i < 26; i++) begin
      if (SC_LETTERS[i] == code) idx = 5'(i + 1);
    end
    return idx;
  endfunction

  function automatic logic [7:0] seg7(input logic [3:0] d);
    logic [7:0] pat;
    pat = SEG_BLANK;
    if (d <= 4'd9) pat = SEG_DIGITS[d];
    return pat;
  endfunction

endpackage

// File: rtl/ps2_frame_rx.sv
// PS/2 11-bit frame receiver with 2-flop synchronisers, frame checking and a mid-frame abort timeout.
// byte_vld_o / err_o pulse one cycle after the stop-bit falling edge is seen; no backpressure (device-paced).
module ps2_frame_rx #(
  parameter int CLK_HZ     = 100_000_000,
  parameter int TIMEOUT_US = 2000
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       ps2_clk_i,
  input  logic       ps2_dat_i,
  output logic [7:0] byte_dat_o,
  output logic       byte_vld_o,
  output logic       err_o
);

  localparam longint TO_CYC = (longint'(CLK_HZ) * longint'(TIMEOUT_US)) / 64'd1_000_000;
  localparam longint TO_LIM = (TO_CYC < 1) ? 1 : TO_CYC;
  localparam int     TO_W   = ($clog2(TO_LIM) < 1) ? 1 : $clog2(TO_LIM);
  localparam logic [TO_W-1:0] TO_MAX = TO_W'(TO_LIM - 1);

  logic            clk_meta_q, clk_sync_q, clk_prev_q;
  logic            dat_meta_q, dat_sync_q;
  logic [3:0]      bit_cnt_q, bit_cnt_d;
  logic [9:0]      shift_q, shift_d;
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
  logic [7:0]      byte_q, byte_d;
  logic            vld_q, vld_d;
  logic            err_q, err_d;
  logic            fall;

  assign fall = clk_prev_q & ~clk_sync_q;

  always_comb begin
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    to_cnt_d  = to_cnt_q;
    byte_d    = byte_q;
    vld_d     = 1'b0;
    err_d     = 1'b0;
    if (fall) begin
      to_cnt_d = '0;
      if (bit_cnt_q == 4'd10) begin
        // shift_q = {parity, d7..d0, start}; current sample is the stop bit.
        bit_cnt_d = '0;
        if (!shift_q[0] && dat_sync_q && (^shift_q[9:1])) begin
          vld_d  = 1'b1;
          byte_d = shift_q[8:1];
        end else begin
          err_d = 1'b1;
        end
      end else begin
        bit_cnt_d = bit_cnt_q + 4'd1;
        shift_d   = {dat_sync_q, shift_q[9:1]};
      end
    end else if (bit_cnt_q != 4'd0) begin
      if (to_cnt_q == TO_MAX) begin
        bit_cnt_d = '0;
        to_cnt_d  = '0;
      end else begin
        to_cnt_d = to_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      clk_meta_q <= 1'b1;
      clk_sync_q <= 1'b1;
      clk_prev_q <= 1'b1;
      dat_meta_q <= 1'b1;
      dat_sync_q <= 1'b1;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      to_cnt_q   <= '0;
      byte_q     <= '0;
      vld_q      <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      clk_meta_q <= ps2_clk_i;
      clk_sync_q <= clk_meta_q;
      clk_prev_q <= clk_sync_q;
      dat_meta_q <= ps2_dat_i;
      dat_sync_q <= dat_meta_q;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      to_cnt_q   <= to_cnt_d;
      byte_q     <= byte_d;
      vld_q      <= vld_d;
      err_q      <= err_d;
    end
  end

  assign byte_dat_o = byte_q;
  assign byte_vld_o = vld_q;
  assign err_o      = err_q;

endmodule

// File: rtl/ps2_key_scroll.sv
// PS/2 keyboard letters scrolled into NUM_KEYS two-digit slots on a multiplexed 7-segment display.
// key_valid one cycle after a byte completes, display changes on the next scan step; no backpressure.
module ps2_key_scroll
  import ps2_key_scroll_pkg::*;
#(
  parameter int CLK_HZ     = 100_000_000,
  parameter int NUM_KEYS   = 4,
  parameter int SCAN_HZ    = 1000,
  parameter int TIMEOUT_US = 2000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clk_in,
  input  logic       data_in,
  output logic [7:0] DIG,
  output logic [7:0] SEG,
  output logic       key_valid,
  output logic [4:0] key_idx,
  output logic       frame_err
);

  localparam int SCAN_DIV = (CLK_HZ / SCAN_HZ < 1) ? 1 : CLK_HZ / SCAN_HZ;
  localparam int SC_W     = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [SC_W-1:0] SC_MAX  = SC_W'(SCAN_DIV - 1);
  localparam logic [2:0]     LAST_DIG = 3'(2 * NUM_KEYS - 1);

  logic [7:0] rx_byte;
  logic       rx_vld;
  logic       rx_err;

  ps2_frame_rx #(
    .CLK_HZ    (CLK_HZ),
    .TIMEOUT_US(TIMEOUT_US)
  ) u_rx (
    .clk_i     (clk),
    .rst_i     (rst),
    .ps2_clk_i (clk_in),
    .ps2_dat_i (data_in),
    .byte_dat_o(rx_byte),
    .byte_vld_o(rx_vld),
    .err_o     (rx_err)
  );

  dec_state_e                 state_q, state_d;
  logic [NUM_KEYS-1:0][4:0]   slot_q, slot_d;
  logic                       key_vld_q, key_vld_d;
  logic [4:0]                 key_idx_q, key_idx_d;
  logic [4:0]                 letter;

  always_comb begin
    state_d   = state_q;
    slot_d    = slot_q;
    key_vld_d = 1'b0;
    key_idx_d = key_idx_q;
    letter    = letter_idx(rx_byte);
    if (rx_vld) begin
      if (rx_byte == SC_BREAK) begin
        state_d = (state_q == DEC_EXT || state_q == DEC_EXT_BREAK) ? DEC_EXT_BREAK : DEC_BREAK;
      end else if (rx_byte == SC_EXT) begin
        state_d = (state_q == DEC_BREAK || state_q == DEC_EXT_BREAK) ? DEC_EXT_BREAK : DEC_EXT;
      end else begin
        // Any non-prefix byte ends a prefix sequence; only IDLE acts on it.
        state_d = DEC_IDLE;
        if (state_q == DEC_IDLE) begin
          if (letter != 5'd0) begin
            for (int i = NUM_KEYS - 1; i > 0; i--) slot_d[i] = slot_q[i-1];
            slot_d[0] = letter;
            key_vld_d = 1'b1;
            key_idx_d = letter;
          end else if (rx_byte == SC_BKSP) begin
            for (int i = 0; i < NUM_KEYS - 1; i++) slot_d[i] = slot_q[i+1];
            slot_d[NUM_KEYS-1] = 5'd0;
          end else if (rx_byte == SC_ENTER) begin
            slot_d = '0;
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= DEC_IDLE;
      slot_q    <= '0;
      key_vld_q <= 1'b0;
      key_idx_q <= '0;
    end else begin
      state_q   <= state_d;
      slot_q    <= slot_d;
      key_vld_q <= key_vld_d;
      key_idx_q <= key_idx_d;
    end
  end

  logic [SC_W-1:0] scan_cnt_q;
  logic [2:0]      dig_q, dig_nxt;
  logic [7:0]      dig_oh_q, seg_q, seg_nxt;
  logic [4:0]      cur;
  logic [3:0]      tens, units;
  logic            tick;

  assign tick = (scan_cnt_q == SC_MAX);

  // Glyph for the digit about to be shown: even digits carry units, odd digits tens.
  always_comb begin
    dig_nxt = (dig_q == LAST_DIG) ? 3'd0 : dig_q + 3'd1;
    cur     = '0;
    for (int k = 0; k < NUM_KEYS; k++) begin
      if (dig_nxt[2:1] == 2'(k)) cur = slot_q[k];
    end
    tens  = 4'(cur / 5'd10);
    units = 4'(cur % 5'd10);
    if (cur == 5'd0) begin
      seg_nxt = SEG_BLANK;
    end else if (dig_nxt[0]) begin
      seg_nxt = (tens == 4'd0) ? SEG_BLANK : seg7(tens);
    end else begin
      seg_nxt = seg7(units);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      scan_cnt_q <= '0;
      dig_q      <= LAST_DIG;
      dig_oh_q   <= 8'hFF;
      seg_q      <= SEG_BLANK;
    end else begin
      scan_cnt_q <= tick ? '0 : scan_cnt_q + 1'b1;
      if (tick) begin
        dig_q    <= dig_nxt;
        dig_oh_q <= ~(8'd1 << dig_nxt);
        seg_q    <= seg_nxt;
      end
    end
  end

  assign DIG       = dig_oh_q;
  assign SEG       = seg_q;
  assign key_valid = key_vld_q;
  assign key_idx   = key_idx_q;
  assign frame_err = rx_err;

endmodule
